// File: rtl/softermax_row_scheduler_if.sv
// Bus bundle for softermax_row_scheduler: upstream beats, shared engine bus, downstream beats.
// SOFTERMAX_SCHED_PERF_EN adds the perf_rows/perf_stall counters to the bundle.
interface softermax_row_scheduler_if #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned PARALLELISM = 1,
   parameter int unsigned NUM_ENGINES = 2
);
   logic [PARALLELISM-1:0][WIDTH-1:0]                  in_data;
   logic                                               in_valid;
   logic                                               in_ready;
   logic [PARALLELISM-1:0][WIDTH-1:0]                  eng_in_data;
   logic [NUM_ENGINES-1:0]                             eng_in_valid;
   logic [NUM_ENGINES-1:0]                             eng_in_ready;
   logic [NUM_ENGINES-1:0][PARALLELISM-1:0][WIDTH-1:0] eng_out_data;
   logic [NUM_ENGINES-1:0]                             eng_out_valid;
   logic [NUM_ENGINES-1:0]                             eng_out_ready;
   logic [PARALLELISM-1:0][WIDTH-1:0]                  out_data;
   logic                                               out_valid;
   logic                                               out_ready;
   logic [7:0]                                         inflight;
`ifdef SOFTERMAX_SCHED_PERF_EN
   logic [31:0]                                        perf_rows;
   logic [31:0]                                        perf_stall;

   modport master (
      output in_data, in_valid, eng_in_ready, eng_out_data, eng_out_valid, out_ready,
      input  in_ready, eng_in_data, eng_in_valid, eng_out_ready, out_data, out_valid,
      input  inflight, perf_rows, perf_stall
   );
   modport slave (
      input  in_data, in_valid, eng_in_ready, eng_out_data, eng_out_valid, out_ready,
      output in_ready, eng_in_data, eng_in_valid, eng_out_ready, out_data, out_valid,
      output inflight, perf_rows, perf_stall
   );
`else
   modport master (
      output in_data, in_valid, eng_in_ready, eng_out_data, eng_out_valid, out_ready,
      input  in_ready, eng_in_data, eng_in_valid, eng_out_ready, out_data, out_valid,
      input  inflight
   );
   modport slave (
      input  in_data, in_valid, eng_in_ready, eng_out_data, eng_out_valid, out_ready,
      output in_ready, eng_in_data, eng_in_valid, eng_out_ready, out_data, out_valid,
      output inflight
   );
`endif
endinterface

// File: rtl/softermax_row_scheduler.sv
// Round-robin row dispatcher/collector for a bank of softermax row engines; output row order = input order.
// Optional SOFTERMAX_SCHED_PERF_EN: perf_rows (rows done, wrapping) and perf_stall (saturating) counters.
module softermax_row_scheduler #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned TOTAL_DIM    = 10,
   parameter int unsigned PARALLELISM  = 1,
   parameter int unsigned NUM_ENGINES  = 2,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input logic                     clk,
   input logic                     rst,
   softermax_row_scheduler_if.slave bus
);
   localparam int unsigned BEATS = TOTAL_DIM / PARALLELISM;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned EW    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   localparam logic [BW-1:0] LAST_BEAT    = BW'(BEATS - 1);
   localparam logic [EW-1:0] LAST_ENG     = EW'(NUM_ENGINES - 1);
   localparam logic [7:0]    INFLIGHT_MAX = 8'(MAX_INFLIGHT);

   if (TOTAL_DIM % PARALLELISM != 0) begin : g_bad_dim
      $error("softermax_row_scheduler: TOTAL_DIM must be a multiple of PARALLELISM");
   end
   if (NUM_ENGINES < 1) begin : g_bad_eng
      $error("softermax_row_scheduler: NUM_ENGINES must be >= 1");
   end
   if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 255) begin : g_bad_inflight
      $error("softermax_row_scheduler: MAX_INFLIGHT must be in 1..255");
   end

   logic [EW-1:0] disp_ptr, coll_ptr;
   logic [BW-1:0] disp_beat, coll_beat;
   logic [7:0]    inflight_q;
   logic          gate, disp_hs, coll_hs, row_start, row_done;

   // Only a row start is throttled; beats inside a started row always flow.
   assign gate = (disp_beat != '0) || (inflight_q < INFLIGHT_MAX);

   always_comb begin
      bus.eng_in_valid  = '0;
      bus.eng_out_ready = '0;
      if (!rst) begin
         bus.eng_in_valid[disp_ptr]  = bus.in_valid && gate;
         bus.eng_out_ready[coll_ptr] = bus.out_ready;
      end
   end

   assign bus.in_ready    = !rst && gate && bus.eng_in_ready[disp_ptr];
   assign bus.eng_in_data = bus.in_data;
   assign bus.out_valid   = !rst && bus.eng_out_valid[coll_ptr];
   assign bus.out_data    = bus.eng_out_data[coll_ptr];
   assign bus.inflight    = inflight_q;

   assign disp_hs   = bus.in_valid && bus.in_ready;
   assign coll_hs   = bus.out_valid && bus.out_ready;
   assign row_start = disp_hs && (disp_beat == '0);
   assign row_done  = coll_hs && (coll_beat == LAST_BEAT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_ptr   <= '0;
         disp_beat  <= '0;
         coll_ptr   <= '0;
         coll_beat  <= '0;
         inflight_q <= '0;
      end else begin
         if (disp_hs) begin
            if (disp_beat == LAST_BEAT) begin
               disp_beat <= '0;
               disp_ptr  <= (disp_ptr == LAST_ENG) ? '0 : disp_ptr + 1'b1;
            end else begin
               disp_beat <= disp_beat + 1'b1;
            end
         end
         if (coll_hs) begin
            if (coll_beat == LAST_BEAT) begin
               coll_beat <= '0;
               coll_ptr  <= (coll_ptr == LAST_ENG) ? '0 : coll_ptr + 1'b1;
            end else begin
               coll_beat <= coll_beat + 1'b1;
            end
         end
         case ({row_start, row_done})
            2'b10:   inflight_q <= inflight_q + 8'd1;
            2'b01:   inflight_q <= inflight_q - 8'd1;
            default: inflight_q <= inflight_q;
         endcase
      end
   end

`ifdef SOFTERMAX_SCHED_PERF_EN
   logic [31:0] perf_rows_q, perf_stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_rows_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (row_done) perf_rows_q <= perf_rows_q + 32'd1;
         if (bus.in_valid && !bus.in_ready && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign bus.perf_rows  = perf_rows_q;
   assign bus.perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_softermax_row_scheduler.sv
// Directed bench for softermax_row_scheduler with two row-buffering engine models.
// Beat (row r, beat b) carries r*16+b; an engine returns each beat XOR 8'h5A once its whole row is in.
module tb_softermax_row_scheduler;
   logic clk;
   logic rst;

   softermax_row_scheduler_if #(.WIDTH(8), .PARALLELISM(1), .NUM_ENGINES(2)) bus ();

   softermax_row_scheduler #(
      .WIDTH(8), .TOTAL_DIM(10), .PARALLELISM(1), .NUM_ENGINES(2), .MAX_INFLIGHT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // source, engines, sink
   logic [7:0] src_mem [64];
   int         src_len, src_pos;
   logic       src_en, sink_rdy;
   logic [1:0] eng_rdy, hold, force_v;
   logic [7:0] eng_mem [2][64];
   int         eng_wr [2];
   int         eng_rd [2];
   logic       have0, have1;
   logic [7:0] out_mem [64];
   logic [1:0] dst_mem [64];
   int         out_cnt, acc_cnt, peak;

   assign bus.in_valid      = src_en && (src_pos < src_len);
   assign bus.in_data       = src_mem[src_pos[5:0]];
   assign bus.eng_in_ready  = eng_rdy;
   assign have0             = (eng_wr[0] / 10) > (eng_rd[0] / 10);
   assign have1             = (eng_wr[1] / 10) > (eng_rd[1] / 10);
   assign bus.eng_out_valid = ({have1, have0} & ~hold) | force_v;
   assign bus.eng_out_data  = {eng_mem[1][eng_rd[1][5:0]] ^ 8'h5A, eng_mem[0][eng_rd[0][5:0]] ^ 8'h5A};
   assign bus.out_ready     = sink_rdy;

   always @(posedge clk) begin
      if (rst) begin
         src_pos <= 0;
         acc_cnt <= 0;
         out_cnt <= 0;
         peak    <= 0;
         for (int k = 0; k < 2; k++) begin
            eng_wr[k] <= 0;
            eng_rd[k] <= 0;
         end
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            src_pos <= src_pos + 1;
            acc_cnt <= acc_cnt + 1;
            dst_mem[acc_cnt[5:0]] <= bus.eng_in_valid;
         end
         for (int k = 0; k < 2; k++) begin
            if (bus.eng_in_valid[k] && bus.eng_in_ready[k]) begin
               eng_mem[k][eng_wr[k][5:0]] <= bus.eng_in_data[0];
               eng_wr[k] <= eng_wr[k] + 1;
            end
            if (bus.eng_out_valid[k] && bus.eng_out_ready[k]) eng_rd[k] <= eng_rd[k] + 1;
         end
         if (bus.out_valid && bus.out_ready) begin
            out_mem[out_cnt[5:0]] <= bus.out_data[0];
            out_cnt <= out_cnt + 1;
         end
         if (int'(bus.inflight) > peak) peak <= int'(bus.inflight);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] beat_val(input int r, input int b);
      return 8'(r * 16 + b);
   endfunction

   task automatic fill_row(input int pos, input int row);
      for (int b = 0; b < 10; b++) src_mem[pos + b] = beat_val(row, b);
   endtask

   task automatic load_rows(input int first, input int n);
      for (int r = first; r < first + n; r++) begin
         fill_row(src_len, r);
         src_len = src_len + 10;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      src_len = 0; src_en = 1'b1; sink_rdy = 1'b0;
      eng_rdy = 2'b11; hold = 2'b00; force_v = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget);
      int t;
      t = 0;
      while (out_cnt < n && t < budget) begin @(negedge clk); t++; end
   endtask

   task automatic wait_acc(input int n, input int budget);
      int t;
      t = 0;
      while (acc_cnt < n && t < budget) begin @(negedge clk); t++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      src_len = 0; src_en = 1'b1; sink_rdy = 1'b1;
      eng_rdy = 2'b11; hold = 2'b00; force_v = 2'b11;
      load_rows(0, 1);
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_eng_in_valid", 32'(bus.eng_in_valid), 32'd0);
      check_eq("rst_eng_out_ready", 32'(bus.eng_out_ready), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_inflight", 32'(bus.inflight), 32'd0);
`ifdef SOFTERMAX_SCHED_PERF_EN
      check_eq("rst_perf_rows", bus.perf_rows, 32'd0);
      check_eq("rst_perf_stall", bus.perf_stall, 32'd0);
`endif

      // 4 rows, everything ready
      reset_dut();
      sink_rdy = 1'b1;
      load_rows(0, 4);
      wait_out(40, 300);
      check_eq("t1_out_count", 32'(out_cnt), 32'd40);
      for (int r = 0; r < 4; r++) begin
         check_eq("t1_route_first", 32'(dst_mem[r * 10]), (r % 2 == 0) ? 32'd1 : 32'd2);
         check_eq("t1_route_last", 32'(dst_mem[r * 10 + 9]), (r % 2 == 0) ? 32'd1 : 32'd2);
      end
      for (int i = 0; i < 40; i++)
         check_eq("t1_out_order", 32'(out_mem[i]), 32'(beat_val(i / 10, i % 10) ^ 8'h5A));
      check_eq("t1_peak", 32'(peak), 32'd2);
      @(negedge clk);
      check_eq("t1_inflight_end", 32'(bus.inflight), 32'd0);

      // inflight limit with a stalled sink
      reset_dut();
      load_rows(0, 3);
      repeat (40) @(negedge clk);
      #1;
      check_eq("t2_accepted", 32'(acc_cnt), 32'd20);
      check_eq("t2_in_valid", 32'(bus.in_valid), 32'd1);
      check_eq("t2_in_ready_gated", 32'(bus.in_ready), 32'd0);
      check_eq("t2_inflight_max", 32'(bus.inflight), 32'd2);
      sink_rdy = 1'b1;
      wait_out(10, 60);
      sink_rdy = 1'b0;
      #1;
      check_eq("t2_out10", 32'(out_cnt), 32'd10);
      check_eq("t2_in_ready_open", 32'(bus.in_ready), 32'd1);
      wait_acc(30, 60);
      check_eq("t2_accepted_3rd", 32'(acc_cnt), 32'd30);
      check_eq("t2_inflight_again", 32'(bus.inflight), 32'd2);
      sink_rdy = 1'b1;
      wait_out(30, 100);
      check_eq("t2_out_all", 32'(out_cnt), 32'd30);
      check_eq("t2_row1_first", 32'(out_mem[10]), 32'(beat_val(1, 0) ^ 8'h5A));
      check_eq("t2_row2_first", 32'(out_mem[20]), 32'(beat_val(2, 0) ^ 8'h5A));
      check_eq("t2_row2_last", 32'(out_mem[29]), 32'(beat_val(2, 9) ^ 8'h5A));

      // eng1 ready before eng0
      reset_dut();
      hold = 2'b01;
      sink_rdy = 1'b1;
      load_rows(0, 2);
      wait_acc(20, 80);
      repeat (3) @(negedge clk);
      #1;
      check_eq("t3_accepted", 32'(acc_cnt), 32'd20);
      check_eq("t3_eng1_has_row", 32'(have1), 32'd1);
      check_eq("t3_out_valid_held", 32'(bus.out_valid), 32'd0);
      check_eq("t3_no_output", 32'(out_cnt), 32'd0);
      check_eq("t3_eng_out_ready", 32'(bus.eng_out_ready), 32'd1);
      hold = 2'b00;
      wait_out(20, 80);
      check_eq("t3_out_count", 32'(out_cnt), 32'd20);
      check_eq("t3_row0_first", 32'(out_mem[0]), 32'(beat_val(0, 0) ^ 8'h5A));
      check_eq("t3_row1_first", 32'(out_mem[10]), 32'(beat_val(1, 0) ^ 8'h5A));
      check_eq("t3_row1_last", 32'(out_mem[19]), 32'(beat_val(1, 9) ^ 8'h5A));

      // row start coincident with last-beat collect
      reset_dut();
      sink_rdy = 1'b1;
      fill_row(0, 0);
      fill_row(10, 1);
      src_len = 10;
      wait_out(9, 60);
      src_len = 20;
      #1;
      check_eq("t4_out9", 32'(out_cnt), 32'd9);
      check_eq("t4_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("t4_eng_in_valid", 32'(bus.eng_in_valid), 32'd2);
      check_eq("t4_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("t4_inflight_before", 32'(bus.inflight), 32'd1);
      @(negedge clk);
      check_eq("t4_out10", 32'(out_cnt), 32'd10);
      check_eq("t4_acc11", 32'(acc_cnt), 32'd11);
      check_eq("t4_inflight_held", 32'(bus.inflight), 32'd1);

      // reset in the middle of a row
      reset_dut();
      sink_rdy = 1'b1;
      load_rows(3, 1);
      wait_acc(5, 30);
      rst = 1'b1;
      force_v = 2'b11;
      #1;
      check_eq("t5_acc5", 32'(acc_cnt), 32'd5);
      check_eq("t5_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("t5_eng_in_valid", 32'(bus.eng_in_valid), 32'd0);
      check_eq("t5_eng_out_ready", 32'(bus.eng_out_ready), 32'd0);
      check_eq("t5_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("t5_inflight", 32'(bus.inflight), 32'd0);
      repeat (2) @(negedge clk);
      force_v = 2'b00;
      src_len = 0;
      rst = 1'b0;
      load_rows(6, 1);
      wait_out(10, 60);
      check_eq("t5_out_count", 32'(out_cnt), 32'd10);
      check_eq("t5_route_eng0", 32'(dst_mem[0]), 32'd1);
      check_eq("t5_row_first", 32'(out_mem[0]), 32'(beat_val(6, 0) ^ 8'h5A));
      check_eq("t5_row_last", 32'(out_mem[9]), 32'(beat_val(6, 9) ^ 8'h5A));

`ifdef SOFTERMAX_SCHED_PERF_EN
      // 7 stalled cycles, then 3 rows through
      reset_dut();
      eng_rdy = 2'b00;
      load_rows(0, 3);
      repeat (7) @(negedge clk);
      eng_rdy = 2'b11;
      sink_rdy = 1'b1;
      wait_out(30, 150);
      @(negedge clk);
      check_eq("t6_out_count", 32'(out_cnt), 32'd30);
      check_eq("t6_perf_rows", bus.perf_rows, 32'd3);
      check_eq("t6_perf_stall", bus.perf_stall, 32'd7);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
